// File: rtl/nios_dct_pkg.sv
// Shared types and constants for the Nios II debug-trace (DCT) frame path.
// Trace-code encodings, frame geometry and the frame bundle type.
package nios_dct_pkg;

    localparam int CODE_W = 2;
    localparam int DEPTH  = 15;
    localparam int BUF_W  = CODE_W * DEPTH;
    localparam int CNT_W  = 4;

    localparam logic [CODE_W-1:0] DCT_NOP = 2'b00;
    localparam logic [CODE_W-1:0] DCT_SEQ = 2'b01;
    localparam logic [CODE_W-1:0] DCT_BR  = 2'b10;
    localparam logic [CODE_W-1:0] DCT_EXC = 2'b11;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [CNT_W-1:0] count;
    } frame_t;

endpackage

// File: rtl/nios_dct_outreg.sv
// Single-entry valid/ready output register for DCT frames.
// Ports: clk, reset_n, load/din (new frame), ready/valid/dout (sink side),
// free (register can take a new frame this cycle).
module nios_dct_outreg
    import nios_dct_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   load,
    input  frame_t din,
    input  logic   ready,
    output logic   valid,
    output frame_t dout,
    output logic   free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios_dct_packer.sv
// Packs 2-bit trace codes into 30-bit DCT frames and hands them off
// over valid/ready. Ports: clk, reset_n, code_valid/code_ready/code_in,
// flush, frame_valid/frame_ready, dct_buffer, dct_count, frame_total.
// Optional idle auto-flush: define NIOS_DCT_PACKER_TIMEOUT_EN.
module nios_dct_packer
    import nios_dct_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_in,
    input  logic              flush,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic [15:0]       frame_total
);

    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend;

    logic             accept;
    logic [BUF_W-1:0] acc_next;
    logic [CNT_W-1:0] acc_cnt_next;
    logic             flush_req;
    logic             out_free;
    logic             transfer;
    frame_t           frame_in;
    frame_t           frame_out;

    assign code_ready = (acc_cnt != FULL_CNT);
    assign accept     = code_valid && code_ready;

    // Oldest code drifts upward; unused high bits stay zero.
    assign acc_next = accept ? {acc[BUF_W-CODE_W-1:0], code_in} : acc;
    assign acc_cnt_next = acc_cnt + CNT_W'(accept);

    // Decision uses post-accept values so the last code and the
    // hand-off can share a cycle.
    assign transfer = out_free &&
        ((acc_cnt_next == FULL_CNT) ||
         ((flush_req || flush_pend) && (acc_cnt_next != '0)));

`ifdef NIOS_DCT_PACKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] idle_cnt;

    assign flush_req = flush || (idle_cnt == TO_LAST);

    // Saturates at TO_LAST so a blocked output keeps the request up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (accept || transfer) begin
            idle_cnt <= '0;
        end else if ((acc_cnt != '0) && (idle_cnt != TO_LAST)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush_req = flush;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            acc_cnt     <= '0;
            flush_pend  <= 1'b0;
            frame_total <= '0;
        end else if (transfer) begin
            acc         <= '0;
            acc_cnt     <= '0;
            flush_pend  <= 1'b0;
            frame_total <= frame_total + 16'd1;
        end else begin
            acc     <= acc_next;
            acc_cnt <= acc_cnt_next;
            // Remember a flush that could not be served yet;
            // a flush on an empty accumulator is dropped.
            if (flush_req && (acc_cnt_next != '0)) begin
                flush_pend <= 1'b1;
            end
        end
    end

    assign frame_in.buffer = acc_next;
    assign frame_in.count  = acc_cnt_next;

    nios_dct_outreg u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (transfer),
        .din     (frame_in),
        .ready   (frame_ready),
        .valid   (frame_valid),
        .dout    (frame_out),
        .free    (out_free)
    );

    assign dct_buffer = frame_out.buffer;
    assign dct_count  = frame_out.count;

endmodule

// File: tb/tb_nios_dct_packer.sv
// Scoreboard bench for nios_dct_packer: expected frames are queued as
// codes/flushes are driven and compared on each frame hand-off.
module tb_nios_dct_packer;
    import nios_dct_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [1:0]  code_in = '0;
    logic        flush = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frame_total;

    always #5 clk = ~clk;

    nios_dct_packer #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .code_in     (code_in),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .frame_total (frame_total)
    );

    typedef struct {
        logic [29:0] b;
        logic [3:0]  c;
        logic [15:0] t;
    } exp_t;

    exp_t        expq[$];
    logic [1:0]  mcodes[$];
    int          seq = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic void model_emit();
        exp_t e;
        e.b = '0;
        foreach (mcodes[i]) e.b = {e.b[27:0], mcodes[i]};
        e.c = 4'(mcodes.size());
        seq++;
        e.t = 16'(seq);
        expq.push_back(e);
        mcodes.delete();
    endfunction

    function automatic void model_push(input logic [1:0] c);
        mcodes.push_back(c);
        if (mcodes.size() == 15) model_emit();
    endfunction

    function automatic void model_flush();
        if (mcodes.size() > 0) model_emit();
    endfunction

    // Entered and left at posedge+1.
    task automatic send(input logic [1:0] c, input logic fl);
        int n = 0;
        code_valid = 1'b1;
        code_in = c;
        flush = fl;
        @(negedge clk);
        while (!code_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("code_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        model_push(c);
        if (fl) model_flush();
        code_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic        prev_hold = 1'b0;
    logic [29:0] hold_b;
    logic [3:0]  hold_c;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_buf", 32'(dct_buffer), 32'(hold_b));
                chk("hold_cnt", 32'(dct_count), 32'(hold_c));
            end
            prev_hold = frame_valid && !frame_ready;
            hold_b = dct_buffer;
            hold_c = dct_count;
            if (frame_valid && frame_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame", 32'(dct_count), 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("buf", 32'(dct_buffer), 32'(e.b));
                    chk("cnt", 32'(dct_count), 32'(e.c));
                    chk("total", 32'(frame_total), 32'(e.t));
                end
            end
        end
    end

    initial begin
        #3;
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_cr", 32'(code_ready), 32'd1);
        chk("rst_buf", 32'(dct_buffer), 32'd0);
        chk("rst_cnt", 32'(dct_count), 32'd0);
        chk("rst_tot", 32'(frame_total), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);

        // 15 x SEQ, full frame with one-cycle latency
        for (int i = 0; i < 15; i++) send(DCT_SEQ, 1'b0);
        @(negedge clk);
        chk("t1_fv", 32'(frame_valid), 32'd1);
        chk("t1_buf", 32'(dct_buffer), 32'h15555555);
        chk("t1_cnt", 32'(dct_count), 32'd15);
        chk("t1_tot", 32'(frame_total), 32'd1);
        idle(2);

        // partial frame via flush, then flush on empty
        send(DCT_EXC, 1'b0);
        send(DCT_BR, 1'b0);
        send(DCT_SEQ, 1'b0);
        pulse_flush();
        pulse_flush();
        @(negedge clk);
        idle(3);
        @(negedge clk);
        chk("t2_nofv", 32'(frame_valid), 32'd0);
        idle(1);

        // blocked output, 30 codes, back-to-back release
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) send(2'(i * 7 + 1), 1'b0);
        @(negedge clk);
        chk("t3_cr", 32'(code_ready), 32'd0);
        chk("t3_fv", 32'(frame_valid), 32'd1);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_nobubble", 32'(frame_valid), 32'd1);
        chk("t3_cr2", 32'(code_ready), 32'd1);
        idle(3);

        // accept + flush in the same cycle
        for (int i = 0; i < 4; i++) send(DCT_BR, 1'b0);
        send(DCT_EXC, 1'b1);
        @(negedge clk);
        chk("t4_fv", 32'(frame_valid), 32'd1);
        chk("t4_cnt", 32'(dct_count), 32'd5);
        chk("t4_lsb", 32'(dct_buffer[1:0]), 32'(DCT_EXC));
        idle(2);

        // reset with acc_cnt=7 and a held frame
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) send(DCT_SEQ, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_fv", 32'(frame_valid), 32'd0);
        chk("t5_buf", 32'(dct_buffer), 32'd0);
        chk("t5_cnt", 32'(dct_count), 32'd0);
        chk("t5_tot", 32'(frame_total), 32'd0);
        chk("t5_cr", 32'(code_ready), 32'd1);
        expq.delete();
        mcodes.delete();
        seq = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        frame_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("t5_nofv", 32'(frame_valid), 32'd0);
        idle(1);

        // idle timeout
        send(DCT_BR, 1'b0);
        send(DCT_SEQ, 1'b0);
`ifdef NIOS_DCT_PACKER_TIMEOUT_EN
        model_flush();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_valid && n < 200);
            chk("t6_delay", 32'(n), 32'd65);
            chk("t6_cnt", 32'(dct_count), 32'd2);
        end
`else
        begin
            int seen = 0;
            repeat (100) begin
                @(negedge clk);
                if (frame_valid) seen++;
            end
            chk("t6_noframe", 32'(seen), 32'd0);
        end
        @(posedge clk);
        #1;
        pulse_flush();
`endif
        idle(4);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/nios_dct_packer.md
Name: nios_dct_packer

Overview:
- Producer side of the OCI debug-trace frame interface: packs a stream of 2-bit trace codes into a 30-bit dct_buffer with a 4-bit dct_count of valid codes.
- Hands each completed frame to the downstream trace sink / OCI test-bench checker over a valid/ready handshake.
- Sits between the Nios II trace-code generator and the trace capture path.
- Double-buffered: one accumulator plus one output frame register.

Parameters:
- CODE_W, 2, width of one trace code.
- DEPTH, 15, codes per full frame; BUF_W = CODE_W*DEPTH = 30.
- CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > DEPTH.
- TIMEOUT, 64, idle cycles before auto-flush (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- code_valid  in  1  code_in is presented this cycle.
- code_ready  out  1  packer accepts code_in this cycle.
- code_in  in  2  trace code.
- flush  in  1  single-cycle request to emit the partial frame.
- frame_valid  out  1  dct_buffer/dct_count hold a frame.
- frame_ready  in  1  sink accepts the frame this cycle.
- dct_buffer  out  30  packed codes.
- dct_count  out  4  number of valid codes in dct_buffer, 1..15.
- frame_total  out  16  count of frames handed off, wraps at 65535->0.

Behaviour:
- Reset, asynchronous:
  - acc=0, acc_cnt=0, flush_pend=0.
  - frame_valid=0, dct_buffer=0, dct_count=0, frame_total=0, code_ready=1.
- Accept: code accepted when code_valid && code_ready.
  - acc <= {acc[27:0], code_in}; acc_cnt +1.
  - Oldest code sits at bits [2*cnt-1 : 2*cnt-2]; newest at [1:0]; unused high bits are zero.
- code_ready = (acc_cnt != 15). Combinational from state only, never from code_valid.
- out_free = !frame_valid || frame_ready.
- Transfer to output when out_free and either condition holds (evaluated on post-accept values, so an accept and a transfer can happen in the same cycle):
  - (a) acc_cnt_next == 15; or
  - (b) (flush || flush_pend) && acc_cnt_next > 0.
- On transfer:
  - dct_buffer <= acc_next, dct_count <= acc_cnt_next.
  - frame_valid <= 1, frame_total +1.
  - acc <= 0, acc_cnt <= 0, flush_pend <= 0.
- Latency: the 15th code accepted at edge N makes frame_valid high after edge N, provided the output was free.
- Output held stable while frame_valid && !frame_ready.
- frame_valid clears after the handshake unless a new transfer occurs in the same cycle (back-to-back frames, no bubble).
- Full accumulator with a blocked output:
  - acc_cnt stays 15, code_ready=0.
  - Transfer happens in the first cycle out_free=1.
- Flush behaviour:
  - flush with acc_cnt_next == 0: ignored, no empty frame, flush_pend unchanged.
  - flush while the output is blocked: sets flush_pend; the partial frame is emitted when the output frees.
  - Codes accepted meanwhile are included in that frame.
- Simultaneous code accept and flush: the code is included in the flushed frame.
- Reset mid-frame discards acc and the output frame; no partial frame is emitted.

Optional Feature:
- Macro: NIOS_DCT_PACKER_TIMEOUT_EN.
- With it: a CNT counter increments each cycle with acc_cnt>0 and no accept. The counter clears on accept or transfer. Reaching TIMEOUT-1 acts as an internal flush request, identical to flush.
- Without it: no counter; partial frames leave only via flush.

Decomposition:
- Shared package nios_dct_pkg:
  - CODE_W, DEPTH, BUF_W, CNT_W.
  - Trace-code constants: DCT_NOP=2'b00, DCT_SEQ=2'b01, DCT_BR=2'b10, DCT_EXC=2'b11.
  - Frame typedef {buffer[29:0], count[3:0]}.
- Sub-module nios_dct_outreg: single-entry valid/ready output register (load, hold, handshake), reused by the trace capture path.

Test Plan:
- Reset, then 15 consecutive codes 2'b01 with frame_ready=1 -> frame_valid one cycle after the last accept; dct_buffer=30'h15555555, dct_count=15, frame_total=1.
- Codes 3,2,1 then flush pulse -> dct_buffer=30'h39, dct_count=3; a second flush with an empty accumulator produces no frame.
- frame_ready=0 while sending 30 codes -> first frame held stable; code_ready=0 after 15 further codes; raising frame_ready -> second frame emitted with no bubble; no codes lost.
- code_valid and flush in the same cycle with acc_cnt=4 -> frame with dct_count=5 containing the flush-cycle code in [1:0].
- reset_n low for 1 cycle with acc_cnt=7 and frame_valid=1 -> all outputs zero immediately, code_ready=1.
- With NIOS_DCT_PACKER_TIMEOUT_EN and TIMEOUT=64: 2 codes then idle -> frame (dct_count=2) after 64 idle cycles; without the macro -> no frame emitted.
